branch_predictor: RTL and testbench

//   Predicts branch direction and target at fetch. Owns a direct-mapped table of
//   2-bit saturating counters plus a branch target buffer (BTB).

---
 rtl/branch_predictor_if.sv | 63 ++++++
 rtl/branch_predictor.sv | 176 +++++++++++++++++
 tb/tb_branch_predictor.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch/execute port bundle of the branch predictor.
//
// Handshake: ex_valid is a one-cycle qualifier with no ready/backpressure.
// When ex_valid=1 the ex_* fields describe one resolved conditional branch
// and are consumed at that rising edge; when ex_valid=0 the ex_* fields are
// ignored. The IF side is a pure combinational lookup: if_pred_* follow
// if_pc within the same cycle.
interface branch_predictor_if #(
  parameter int XLEN = 32
);
  // Fetch-side lookup
  logic [XLEN-1:0] if_pc;
  logic            if_pred_taken;
  logic [XLEN-1:0] if_pred_target;

  // Execute-side resolution
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic            ex_taken;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;
  logic            ex_redirect;
  logic [XLEN-1:0] ex_redirect_pc;

  // Performance counters
  logic [31:0]     branch_count;
  logic [31:0]     mispredict_count;

  // Pipeline side: drives PCs and resolutions, consumes predictions
  modport master (
    output if_pc,
    input  if_pred_taken,
    input  if_pred_target,
    output ex_valid,
    output ex_pc,
    output ex_taken,
    output ex_target,
    output ex_pred_taken,
    output ex_pred_target,
    input  ex_redirect,
    input  ex_redirect_pc,
    input  branch_count,
    input  mispredict_count
  );

  // Predictor side
  modport slave (
    input  if_pc,
    output if_pred_taken,
    output if_pred_target,
    input  ex_valid,
    input  ex_pc,
    input  ex_taken,
    input  ex_target,
    input  ex_pred_taken,
    input  ex_pred_target,
    output ex_redirect,
    output ex_redirect_pc,
    output branch_count,
    output mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: 2-bit saturating direction counters plus a
// branch target buffer, trained from EX resolution. Raises the EX redirect on
// a direction or target mispredict and counts branch / mispredict events.
// XLEN must match the XLEN of the connected branch_predictor_if.
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int XLEN       = 32
) (
  input logic               clk,
  input logic               reset,
  branch_predictor_if.slave bus
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = XLEN - INDEX_BITS - 2;

  localparam logic [1:0] CTR_RESET = 2'b01;  // weakly not-taken
  localparam logic [1:0] CTR_ALLOC = 2'b10;  // weakly taken
  localparam logic [1:0] CTR_MAX   = 2'b11;
  localparam logic [1:0] CTR_MIN   = 2'b00;

  // Table storage. valid/ctr are reset; tag/target are only meaningful
  // while valid=1, so they carry no reset.
  logic             entry_valid  [ENTRIES];
  logic [TAG_W-1:0] entry_tag    [ENTRIES];
  logic [XLEN-1:0]  entry_target [ENTRIES];
  logic [1:0]       entry_ctr    [ENTRIES];

  logic [31:0] branch_count_q;
  logic [31:0] mispredict_count_q;

  // ------------------------------------------------------------------
  // Address decode
  // ------------------------------------------------------------------
  logic [INDEX_BITS-1:0] if_idx;
  logic [TAG_W-1:0]      if_tag;
  logic [INDEX_BITS-1:0] ex_idx;
  logic [TAG_W-1:0]      ex_tag;

  assign if_idx = bus.if_pc[INDEX_BITS+1:2];
  assign if_tag = bus.if_pc[XLEN-1:INDEX_BITS+2];
  assign ex_idx = bus.ex_pc[INDEX_BITS+1:2];
  assign ex_tag = bus.ex_pc[XLEN-1:INDEX_BITS+2];

  // Sequential fall-through addresses; the +4 wraps modulo 2**XLEN.
  logic [XLEN-1:0] if_pc_plus4;
  logic [XLEN-1:0] ex_pc_plus4;

  assign if_pc_plus4 = bus.if_pc + XLEN'(4);
  assign ex_pc_plus4 = bus.ex_pc + XLEN'(4);

  // ------------------------------------------------------------------
  // Fetch lookup: reads registered state only, so an update at the same
  // index in the same cycle is not seen until the following cycle.
  // ------------------------------------------------------------------
  logic if_hit;

  // Tag compare and direction/target selection for the fetch PC
  always_comb begin
    if_hit             = entry_valid[if_idx] && (entry_tag[if_idx] == if_tag);
    bus.if_pred_taken  = if_hit && entry_ctr[if_idx][1];
    bus.if_pred_target = if_pc_plus4;
    if (bus.if_pred_taken) begin
      bus.if_pred_target = entry_target[if_idx];
    end
  end

  // ------------------------------------------------------------------
  // EX-side hit detection and next counter value
  // ------------------------------------------------------------------
  logic       ex_hit;
  logic [1:0] ex_ctr_cur;
  logic [1:0] ex_ctr_next;
  logic       ex_alloc;
  logic       ex_ctr_write;
  logic       ex_target_write;

  // Decide what the resolving branch does to its table entry
  always_comb begin
    ex_hit          = entry_valid[ex_idx] && (entry_tag[ex_idx] == ex_tag);
    ex_ctr_cur      = entry_ctr[ex_idx];
    ex_ctr_next     = ex_ctr_cur;
    ex_alloc        = 1'b0;
    ex_ctr_write    = 1'b0;
    ex_target_write = 1'b0;
    if (bus.ex_valid) begin
      if (ex_hit) begin
        ex_ctr_write = 1'b1;
        if (bus.ex_taken) begin
          ex_target_write = 1'b1;
          ex_ctr_next     = (ex_ctr_cur == CTR_MAX) ? CTR_MAX : ex_ctr_cur + 2'd1;
        end else begin
          ex_ctr_next     = (ex_ctr_cur == CTR_MIN) ? CTR_MIN : ex_ctr_cur - 2'd1;
        end
      end else if (bus.ex_taken) begin
        // A taken miss claims the slot, evicting any alias at this index.
        ex_alloc        = 1'b1;
        ex_ctr_write    = 1'b1;
        ex_target_write = 1'b1;
        ex_ctr_next     = CTR_ALLOC;
      end
      // A not-taken miss leaves the table untouched.
    end
  end

  // ------------------------------------------------------------------
  // Redirect: direction mismatch, or taken with a wrong predicted target.
  // ------------------------------------------------------------------
  logic dir_wrong;
  logic target_wrong;

  assign dir_wrong    = (bus.ex_pred_taken != bus.ex_taken);
  assign target_wrong = bus.ex_taken && (bus.ex_pred_target != bus.ex_target);

  // Mispredict flag and correct next PC for the resolving branch
  always_comb begin
    bus.ex_redirect    = bus.ex_valid && (dir_wrong || target_wrong);
    bus.ex_redirect_pc = bus.ex_taken ? bus.ex_target : ex_pc_plus4;
  end

  // ------------------------------------------------------------------
  // Table state
  // ------------------------------------------------------------------

  // Valid bits and direction counters; reset wins over a same-cycle update
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entry_valid[i] <= 1'b0;
        entry_ctr[i]   <= CTR_RESET;
      end
    end else begin
      if (ex_alloc) begin
        entry_valid[ex_idx] <= 1'b1;
      end
      if (ex_ctr_write) begin
        entry_ctr[ex_idx] <= ex_ctr_next;
      end
    end
  end

  // Tags and targets; updates are suppressed while reset is asserted
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (ex_alloc) begin
        entry_tag[ex_idx] <= ex_tag;
      end
      if (ex_target_write) begin
        entry_target[ex_idx] <= bus.ex_target;
      end
    end
  end

  // ------------------------------------------------------------------
  // Performance counters (free-running, wrap at 2**32)
  // ------------------------------------------------------------------

  // Count resolved branches and raised redirects
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count_q     <= 32'd0;
      mispredict_count_q <= 32'd0;
    end else begin
      if (bus.ex_valid) begin
        branch_count_q <= branch_count_q + 32'd1;
      end
      if (bus.ex_redirect) begin
        mispredict_count_q <= mispredict_count_q + 32'd1;
      end
    end
  end

  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: reset state, counter training and
// saturation, aliasing, read-before-write, redirect generation, PC wrap,
// reset-over-update priority and performance counter wrap.
module tb_branch_predictor;

  localparam int XLEN = 32;

  logic clk;
  logic reset;

  branch_predictor_if #(.XLEN(XLEN)) bus ();

  branch_predictor #(.INDEX_BITS(6), .XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ----------------------------------------------------------------
  // Clock / reset
  // ----------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ----------------------------------------------------------------
  // Scoreboard
  // ----------------------------------------------------------------
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_br  = 32'd0;
  logic [31:0] exp_mis = 32'd0;

  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp_v;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s observed=%h expected=<queue empty>", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
    end
  endtask

  // ----------------------------------------------------------------
  // Driver tasks (all drive at the falling edge, sample #1 later)
  // ----------------------------------------------------------------
  task automatic next_cycle();
    @(negedge clk);
    bus.ex_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    bus.if_pc          = '0;
    bus.ex_valid       = 1'b0;
    bus.ex_pc          = '0;
    bus.ex_taken       = 1'b0;
    bus.ex_target      = '0;
    bus.ex_pred_taken  = 1'b0;
    bus.ex_pred_target = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic exp_taken,
                        input logic [31:0] exp_target);
    bus.if_pc = pc;
    push_exp({31'd0, exp_taken});
    push_exp(exp_target);
    #1;
    check("if_pred_taken", {31'd0, bus.if_pred_taken});
    check("if_pred_target", bus.if_pred_target);
  endtask

  task automatic check_counts();
    push_exp(exp_br);
    push_exp(exp_mis);
    #1;
    check("branch_count", bus.branch_count);
    check("mispredict_count", bus.mispredict_count);
  endtask

  // Starts a new cycle with one resolving branch and checks the redirect.
  task automatic resolve(input logic [31:0] pc, input logic taken,
                         input logic [31:0] target, input logic ptaken,
                         input logic [31:0] ptarget, input logic exp_red,
                         input logic [31:0] exp_rpc);
    next_cycle();
    bus.ex_valid       = 1'b1;
    bus.ex_pc          = pc;
    bus.ex_taken       = taken;
    bus.ex_target      = target;
    bus.ex_pred_taken  = ptaken;
    bus.ex_pred_target = ptarget;
    push_exp({31'd0, exp_red});
    push_exp(exp_rpc);
    #1;
    check("ex_redirect", {31'd0, bus.ex_redirect});
    check("ex_redirect_pc", bus.ex_redirect_pc);
    exp_br = exp_br + 32'd1;
    if (exp_red) exp_mis = exp_mis + 32'd1;
  endtask

  // ----------------------------------------------------------------
  // Directed sequence
  // ----------------------------------------------------------------
  initial begin
    logic [31:0] r_pc, r_tg, r_ptg;
    logic        r_tk, r_ptk, r_red;

    do_reset();

    // Reset state
    lookup(32'h100, 1'b0, 32'h104);
    check_counts();

    // First taken resolve: redirect, and same-cycle lookup sees old entry
    resolve(32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1, 32'h80);
    lookup(32'h100, 1'b0, 32'h104);
    next_cycle();
    lookup(32'h100, 1'b1, 32'h80);
    check_counts();

    // Decrement ctr 2 -> 1 -> 0 -> 0 (target of not-taken is irrelevant)
    resolve(32'h100, 1'b0, 32'hDEAD0000, 1'b1, 32'h80, 1'b1, 32'h104);
    next_cycle();
    lookup(32'h100, 1'b0, 32'h104);
    resolve(32'h100, 1'b0, 32'hDEAD0000, 1'b0, 32'h104, 1'b0, 32'h104);
    resolve(32'h100, 1'b0, 32'hDEAD0000, 1'b0, 32'h104, 1'b0, 32'h104);
    // One taken: 0 -> 1 still predicts not taken if ctr held at 0
    resolve(32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1, 32'h80);
    next_cycle();
    lookup(32'h100, 1'b0, 32'h104);
    // Taken: 1 -> 2
    resolve(32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1, 32'h80);
    next_cycle();
    lookup(32'h100, 1'b1, 32'h80);
    // Taken, correctly predicted: 2 -> 3
    resolve(32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h80);
    // Taken with a wrong predicted target: 3 stays 3, target -> 0x88
    resolve(32'h100, 1'b1, 32'h88, 1'b1, 32'h80, 1'b1, 32'h88);
    next_cycle();
    lookup(32'h100, 1'b1, 32'h88);
    // Not taken: 3 -> 2 still predicts taken, target kept
    resolve(32'h100, 1'b0, 32'h0, 1'b1, 32'h88, 1'b1, 32'h104);
    next_cycle();
    lookup(32'h100, 1'b1, 32'h88);
    // Not taken: 2 -> 1
    resolve(32'h100, 1'b0, 32'h0, 1'b1, 32'h88, 1'b1, 32'h104);
    next_cycle();
    lookup(32'h100, 1'b0, 32'h104);
    check_counts();

    // Alias at index 0: 0x200 evicts 0x100
    resolve(32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1, 32'h80);
    resolve(32'h200, 1'b1, 32'h300, 1'b0, 32'h204, 1'b1, 32'h300);
    next_cycle();
    lookup(32'h100, 1'b0, 32'h104);
    lookup(32'h200, 1'b1, 32'h300);
    // Not-taken miss at the same index leaves the entry alone
    resolve(32'h400, 1'b0, 32'h0, 1'b0, 32'h404, 1'b0, 32'h404);
    next_cycle();
    lookup(32'h200, 1'b1, 32'h300);
    lookup(32'h400, 1'b0, 32'h404);
    // Taken hit updates the target
    resolve(32'h200, 1'b1, 32'h500, 1'b1, 32'h300, 1'b1, 32'h500);
    next_cycle();
    lookup(32'h200, 1'b1, 32'h500);
    check_counts();

    // Read-before-write on a fresh index
    resolve(32'h140, 1'b1, 32'h40, 1'b0, 32'h144, 1'b1, 32'h40);
    lookup(32'h140, 1'b0, 32'h144);
    next_cycle();
    lookup(32'h140, 1'b1, 32'h40);

    // PC +4 wraps modulo 2**32
    lookup(32'hFFFF_FFFC, 1'b0, 32'h0);
    resolve(32'hFFFF_FFFC, 1'b0, 32'h10, 1'b0, 32'h0, 1'b0, 32'h0);

    // No redirect while ex_valid is low, even with mismatched fields
    next_cycle();
    bus.ex_pc          = 32'h300;
    bus.ex_taken       = 1'b1;
    bus.ex_target      = 32'h900;
    bus.ex_pred_taken  = 1'b0;
    bus.ex_pred_target = 32'h304;
    push_exp(32'd0);
    #1;
    check("ex_redirect_idle", {31'd0, bus.ex_redirect});

    // Random resolves against the redirect equation
    for (int i = 0; i < 8; i++) begin
      r_pc  = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
      r_tk  = 1'($urandom_range(0, 1));
      r_ptk = 1'($urandom_range(0, 1));
      r_tg  = 32'h2000 + (32'($urandom_range(0, 1)) << 4);
      r_ptg = 32'h2000 + (32'($urandom_range(0, 1)) << 4);
      r_red = (r_ptk != r_tk) || (r_tk && (r_ptg != r_tg));
      resolve(r_pc, r_tk, r_tg, r_ptk, r_ptg, r_red, r_tk ? r_tg : r_pc + 32'd4);
    end
    next_cycle();
    check_counts();

    // Reset in the same cycle as a resolve: table cleared, update dropped
    reset              = 1'b1;
    bus.ex_valid       = 1'b1;
    bus.ex_pc          = 32'h180;
    bus.ex_taken       = 1'b1;
    bus.ex_target      = 32'h60;
    bus.ex_pred_taken  = 1'b0;
    bus.ex_pred_target = 32'h184;
    next_cycle();
    reset   = 1'b0;
    exp_br  = 32'd0;
    exp_mis = 32'd0;
    lookup(32'h180, 1'b0, 32'h184);
    lookup(32'h140, 1'b0, 32'h144);
    lookup(32'h200, 1'b0, 32'h204);
    check_counts();

    // Counter wrap: preload both counters to all-ones
    next_cycle();
    force dut.branch_count_q     = 32'hFFFF_FFFF;
    force dut.mispredict_count_q = 32'hFFFF_FFFF;
    next_cycle();
    release dut.branch_count_q;
    release dut.mispredict_count_q;
    exp_br  = 32'hFFFF_FFFF;
    exp_mis = 32'hFFFF_FFFF;
    check_counts();
    resolve(32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1, 32'h80);
    next_cycle();
    check_counts();

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
